// File: rtl/switch_pkg.sv
// Shared types and default widths for the NoC switch allocator slice.
package switch_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } alloc_state_t;

  localparam int DEF_NUM_BUFFERS   = 5;
  localparam int DEF_NUM_OUTPORTS  = 5;
  localparam int DEF_NUM_VCS       = 2;
  localparam int DEF_BUFFER_SIZE   = 8;
  localparam int DEF_CREDIT_THRESH = 1;

  localparam int OUTPORT_W = $clog2(DEF_NUM_OUTPORTS);
  localparam int VC_W      = $clog2(DEF_NUM_VCS);
  localparam int BUF_IDX_W = $clog2(DEF_NUM_BUFFERS);
  localparam int CREDIT_W  = $clog2(DEF_BUFFER_SIZE + 1);

endpackage

// File: rtl/switch_allocator_if.sv
// Requester/crossbar-facing bundle of the switch allocator.
interface switch_allocator_if
  import switch_pkg::*;
#(
  parameter int NUM_BUFFERS  = DEF_NUM_BUFFERS,
  parameter int NUM_OUTPORTS = DEF_NUM_OUTPORTS,
  parameter int NUM_VCS      = DEF_NUM_VCS,
  parameter int BUFFER_SIZE  = DEF_BUFFER_SIZE
) ();

  localparam int OW = $clog2(NUM_OUTPORTS);
  localparam int VW = $clog2(NUM_VCS);
  localparam int BW = $clog2(NUM_BUFFERS);
  localparam int CW = $clog2(BUFFER_SIZE + 1);

  // Handshake: req[i] is the valid and is held (with stable outport/VC) until
  // requester i's tail leaves; grant[i] is the response and stays high for the
  // whole packet. It drops the edge after tail_sent[i] or after req[i] falls.
  logic [NUM_BUFFERS-1:0]                       req;
  logic [NUM_BUFFERS-1:0][OW-1:0]               req_outport;
  logic [NUM_BUFFERS-1:0][VW-1:0]               req_vc;
  logic [NUM_BUFFERS-1:0]                       tail_sent;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0][CW-1:0] buffer_availability;
  logic [NUM_BUFFERS-1:0]                       grant;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]         enable;
  logic [NUM_OUTPORTS-1:0][VW-1:0]              outport_vc;
  logic [NUM_OUTPORTS-1:0][BW-1:0]              outport_sel;
  alloc_state_t                                 state [NUM_OUTPORTS];

  modport master (
    output req, req_outport, req_vc, tail_sent, buffer_availability,
    input  grant, enable, outport_vc, outport_sel, state
  );

  modport slave (
    input  req, req_outport, req_vc, tail_sent, buffer_availability,
    output grant, enable, outport_vc, outport_sel, state
  );

endinterface

// File: rtl/switch_rr_arbiter.sv
// Combinational round-robin pick: first eligible index above ptr, wrapping at N.
module switch_rr_arbiter #(
  parameter int N = 5
) (
  input  logic [N-1:0]         elig,
  input  logic [$clog2(N)-1:0] ptr,
  output logic [N-1:0]         onehot,
  output logic [$clog2(N)-1:0] idx,
  output logic                 valid
);

  localparam int IW = $clog2(N);

  int c;

  // Scan from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    c     = 0;
    for (int k = N; k >= 1; k--) begin
      c = (int'(ptr) + k) % N;
      if (elig[IW'(c)]) begin
        valid = 1'b1;
        idx   = IW'(c);
      end
    end
    onehot = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/switch_allocator.sv
// Per-outport round-robin wormhole allocator for the chiplet NoC switch.
// Optional credit gating of eligibility: define SWITCH_ALLOC_CREDIT_GATE_EN.
module switch_allocator
  import switch_pkg::*;
#(
  parameter int NUM_BUFFERS   = DEF_NUM_BUFFERS,
  parameter int NUM_OUTPORTS  = DEF_NUM_OUTPORTS,
  parameter int NUM_VCS       = DEF_NUM_VCS,
  parameter int BUFFER_SIZE   = DEF_BUFFER_SIZE,
  parameter int CREDIT_THRESH = DEF_CREDIT_THRESH
) (
  input logic               clk,
  input logic               nrst,
  switch_allocator_if.slave bus
);

  localparam int VW = $clog2(NUM_VCS);
  localparam int BW = $clog2(NUM_BUFFERS);

  alloc_state_t                           state_q [NUM_OUTPORTS];
  alloc_state_t                           state_d [NUM_OUTPORTS];
  logic [NUM_OUTPORTS-1:0][BW-1:0]        owner_q;
  logic [NUM_OUTPORTS-1:0][BW-1:0]        ptr_q;
  logic [NUM_OUTPORTS-1:0][VW-1:0]        vc_q;
  logic [NUM_OUTPORTS-1:0][NUM_VCS-1:0]   enable_q;
  logic [NUM_BUFFERS-1:0]                 grant_q;
  logic [NUM_BUFFERS-1:0]                 grant_d;
  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] elig;
  logic [NUM_OUTPORTS-1:0][NUM_BUFFERS-1:0] win_oh;
  logic [NUM_OUTPORTS-1:0][BW-1:0]        win_idx;
  logic [NUM_OUTPORTS-1:0]                win_valid;
  logic [NUM_OUTPORTS-1:0]                release_req;
  logic [NUM_OUTPORTS-1:0]                win;
  logic [NUM_OUTPORTS-1:0]                rel;

`ifndef SWITCH_ALLOC_CREDIT_GATE_EN
  logic unused_credits;
  assign unused_credits = ^bus.buffer_availability;
`endif

  // Already-granted requesters are excluded, so no requester can own two outports.
  always_comb begin
    elig        = '0;
    release_req = '0;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      release_req[o] = bus.tail_sent[owner_q[o]] || !bus.req[owner_q[o]];
      for (int i = 0; i < NUM_BUFFERS; i++) begin
        elig[o][i] = bus.req[i] && (int'(bus.req_outport[i]) == o) && !grant_q[i];
`ifdef SWITCH_ALLOC_CREDIT_GATE_EN
        elig[o][i] = elig[o][i] && (int'(bus.req_vc[i]) < NUM_VCS) &&
                     (int'(bus.buffer_availability[o][bus.req_vc[i]]) >= CREDIT_THRESH);
`endif
      end
    end
  end

  for (genvar o = 0; o < NUM_OUTPORTS; o++) begin : g_arb
    switch_rr_arbiter #(.N(NUM_BUFFERS)) u_arb (
      .elig   (elig[o]),
      .ptr    (ptr_q[o]),
      .onehot (win_oh[o]),
      .idx    (win_idx[o]),
      .valid  (win_valid[o])
    );
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      for (int o = 0; o < NUM_OUTPORTS; o++) state_q[o] <= IDLE;
    end else begin
      for (int o = 0; o < NUM_OUTPORTS; o++) state_q[o] <= state_d[o];
    end
  end

  always_comb begin
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      state_d[o] = state_q[o];
      case (state_q[o])
        IDLE:    if (win_valid[o])   state_d[o] = BUSY;
        BUSY:    if (release_req[o]) state_d[o] = IDLE;
        default: state_d[o] = IDLE;
      endcase
    end
  end

  // Releases are applied before wins; a releasing requester is never a winner this cycle.
  always_comb begin
    win     = '0;
    rel     = '0;
    grant_d = grant_q;
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      win[o] = (state_q[o] == IDLE) && win_valid[o];
      rel[o] = (state_q[o] == BUSY) && release_req[o];
    end
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      if (rel[o]) grant_d[owner_q[o]] = 1'b0;
    end
    for (int o = 0; o < NUM_OUTPORTS; o++) begin
      if (win[o]) grant_d = grant_d | win_oh[o];
    end
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      grant_q  <= '0;
      owner_q  <= '0;
      vc_q     <= '0;
      enable_q <= '0;
      for (int o = 0; o < NUM_OUTPORTS; o++) ptr_q[o] <= BW'(NUM_BUFFERS - 1);
    end else begin
      grant_q <= grant_d;
      for (int o = 0; o < NUM_OUTPORTS; o++) begin
        if (win[o]) begin
          owner_q[o]  <= win_idx[o];
          ptr_q[o]    <= win_idx[o];
          vc_q[o]     <= bus.req_vc[win_idx[o]];
          enable_q[o] <= NUM_VCS'(1) << bus.req_vc[win_idx[o]];
        end else if (rel[o]) begin
          enable_q[o] <= '0;
        end
      end
    end
  end

  assign bus.grant       = grant_q;
  assign bus.enable      = enable_q;
  assign bus.outport_vc  = vc_q;
  assign bus.outport_sel = owner_q;
  assign bus.state       = state_q;

endmodule

// File: tb/tb_switch_allocator.sv
// Directed bench for switch_allocator: single grant, contention, fairness, credits, abort, reset.
module tb_switch_allocator;
  import switch_pkg::*;

  localparam int NB = 5;
  localparam int NO = 5;
  localparam int NV = 2;
  localparam int BS = 8;
  localparam int OW = $clog2(NO);
  localparam int VW = $clog2(NV);

  logic clk;
  logic nrst;
  int   n_checks;
  int   n_fail;
  int   order2 [3];
  int   w;
  int   non_owner;

  switch_allocator_if #(.NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV), .BUFFER_SIZE(BS)) bus ();

  switch_allocator #(
    .NUM_BUFFERS(NB), .NUM_OUTPORTS(NO), .NUM_VCS(NV), .BUFFER_SIZE(BS), .CREDIT_THRESH(1)
  ) dut (
    .clk  (clk),
    .nrst (nrst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_req(input int i, input int op, input int vc);
    bus.req[i]         = 1'b1;
    bus.req_outport[i] = OW'(op);
    bus.req_vc[i]      = VW'(vc);
  endtask

  task automatic finish_pkt(input int i, input bit keep);
    bus.tail_sent[i] = 1'b1;
    if (!keep) bus.req[i] = 1'b0;
    tick();
    bus.tail_sent[i] = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    order2   = '{0, 1, 4};
    nrst     = 1'b0;
    bus.req         = '0;
    bus.req_outport = '0;
    bus.req_vc      = '0;
    bus.tail_sent   = '0;
    for (int o = 0; o < NO; o++)
      for (int v = 0; v < NV; v++) bus.buffer_availability[o][v] = 4'(BS);
    tick();
    tick();
    nrst = 1'b1;

    chk("rst_grant", 32'(bus.grant), 32'h0);
    chk("rst_enable", 32'(bus.enable), 32'h0);
    chk("rst_vc", 32'(bus.outport_vc), 32'h0);
    chk("rst_sel", 32'(bus.outport_sel), 32'h0);
    chk("rst_state0", 32'(bus.state[0]), 32'(IDLE));

    // Single request: requester 2 -> outport 3, VC 1
    set_req(2, 3, 1);
    tick();
    chk("single_grant", 32'(bus.grant), 32'b00100);
    chk("single_enable3", 32'(bus.enable[3]), 32'b10);
    chk("single_sel3", 32'(bus.outport_sel[3]), 32'd2);
    chk("single_vc3", 32'(bus.outport_vc[3]), 32'd1);
    chk("single_state3", 32'(bus.state[3]), 32'(BUSY));
    finish_pkt(2, 1'b0);
    chk("single_rel_grant", 32'(bus.grant), 32'h0);
    chk("single_rel_enable", 32'(bus.enable), 32'h0);
    chk("single_hold_sel3", 32'(bus.outport_sel[3]), 32'd2);
    chk("single_hold_vc3", 32'(bus.outport_vc[3]), 32'd1);

    // Contention on outport 1: expected order 0, 1, 4 with one idle cycle between
    set_req(0, 1, 0);
    set_req(1, 1, 0);
    set_req(4, 1, 0);
    for (int k = 0; k < 3; k++) begin
      w = order2[k];
      non_owner = (w == 4) ? 0 : 4;
      tick();
      chk("cont_grant", 32'(bus.grant), 32'(1 << w));
      chk("cont_sel1", 32'(bus.outport_sel[1]), 32'(w));
      chk("cont_enable1", 32'(bus.enable[1]), 32'b01);
      bus.tail_sent[non_owner] = 1'b1;
      tick();
      bus.tail_sent[non_owner] = 1'b0;
      tick();
      chk("cont_hold", 32'(bus.grant), 32'(1 << w));
      finish_pkt(w, 1'b0);
      chk("cont_bubble_grant", 32'(bus.grant), 32'h0);
      chk("cont_bubble_enable1", 32'(bus.enable[1]), 32'h0);
    end

    // Fairness on outport 0: requester 0 re-requests at once, grants alternate
    set_req(0, 0, 1);
    set_req(1, 0, 1);
    for (int k = 0; k < 4; k++) begin
      w = k % 2;
      tick();
      chk("fair_grant", 32'(bus.grant), 32'(1 << w));
      chk("fair_enable0", 32'(bus.enable[0]), 32'b10);
      if (k < 3) begin
        finish_pkt(w, 1'b1);
      end else begin
        bus.req[0] = 1'b0;
        finish_pkt(w, 1'b0);
      end
      chk("fair_bubble", 32'(bus.grant), 32'h0);
    end

    // Out-of-range outport is never granted
    set_req(2, 5, 0);
    tick();
    chk("oor_grant_a", 32'(bus.grant), 32'h0);
    tick();
    chk("oor_grant_b", 32'(bus.grant), 32'h0);
    bus.req[2] = 1'b0;

    // Credits on outport 2, VC 0
    bus.buffer_availability[2][0] = 4'd0;
    set_req(3, 2, 0);
`ifdef SWITCH_ALLOC_CREDIT_GATE_EN
    tick();
    chk("cred_blocked_a", 32'(bus.grant), 32'h0);
    tick();
    chk("cred_blocked_b", 32'(bus.grant), 32'h0);
    bus.buffer_availability[2][0] = 4'd3;
    tick();
    chk("cred_granted", 32'(bus.grant), 32'b01000);
    bus.buffer_availability[2][0] = 4'd0;
    tick();
    chk("cred_busy_ignores", 32'(bus.grant), 32'b01000);
`else
    tick();
    chk("cred_ungated_grant", 32'(bus.grant), 32'b01000);
    tick();
    chk("cred_ungated_hold", 32'(bus.grant), 32'b01000);
`endif
    chk("cred_enable2", 32'(bus.enable[2]), 32'b01);
    finish_pkt(3, 1'b0);
    chk("cred_rel", 32'(bus.grant), 32'h0);
    bus.buffer_availability[2][0] = 4'(BS);

    // Abort on outport 4: owner 0 drops req, waiting requester 2 follows
    set_req(0, 4, 0);
    set_req(2, 4, 1);
    tick();
    chk("abort_first", 32'(bus.grant), 32'b00001);
    chk("abort_enable4", 32'(bus.enable[4]), 32'b01);
    bus.req[0] = 1'b0;
    tick();
    chk("abort_idle_grant", 32'(bus.grant), 32'h0);
    chk("abort_idle_enable4", 32'(bus.enable[4]), 32'h0);
    chk("abort_idle_state4", 32'(bus.state[4]), 32'(IDLE));
    tick();
    chk("abort_next_grant", 32'(bus.grant), 32'b00100);
    chk("abort_next_enable4", 32'(bus.enable[4]), 32'b10);
    chk("abort_next_sel4", 32'(bus.outport_sel[4]), 32'd2);
    finish_pkt(2, 1'b0);
    chk("abort_rel", 32'(bus.grant), 32'h0);

    // Asynchronous reset with three outports busy
    set_req(0, 0, 1);
    set_req(1, 1, 1);
    set_req(2, 2, 1);
    tick();
    chk("rb_grant", 32'(bus.grant), 32'b00111);
    chk("rb_enable", 32'(bus.enable[2:0]), 32'b10_10_10);
    #3;
    nrst = 1'b0;
    #1;
    chk("ra_grant", 32'(bus.grant), 32'h0);
    chk("ra_enable", 32'(bus.enable), 32'h0);
    chk("ra_sel", 32'(bus.outport_sel), 32'h0);
    chk("ra_vc", 32'(bus.outport_vc), 32'h0);
    chk("ra_state0", 32'(bus.state[0]), 32'(IDLE));
    bus.req = '0;
    set_req(0, 0, 0);
    set_req(1, 0, 0);
    tick();
    chk("ra_held_grant", 32'(bus.grant), 32'h0);
    nrst = 1'b1;
    tick();
    chk("ra_prio_grant", 32'(bus.grant), 32'b00001);
    chk("ra_prio_sel0", 32'(bus.outport_sel[0]), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
